vga_timing_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator running in the pixel-clock domain. Produces hsync/vsync/data-enable for any resolution set by parameters, with programmable sync polarity, per-pixel coordinates, a frame-start strobe and four selectable test patterns. It sits between the pixel-clock PLL and the VGA/HDMI output pins. It is the generalised successor of the fixed 640x480 demo timing, adding multi-resolution support, polarity control, coordinate export and pattern modes.

---
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing and test-pattern generator: parametrised resolution, programmable sync polarity, coordinate export.
// All outputs are registered one pixel clock after the counter state they describe; free-running, no backpressure.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int COLOR_W   = 8,
    parameter int GRID_LOG2 = 5
) (
    input  logic                                                 vga_clk,
    input  logic                                                 rst,
    input  logic [1:0]                                           mode,
    input  logic [3*COLOR_W-1:0]                                 solid_rgb,
    output logic                                                 vga_hs,
    output logic                                                 vga_vs,
    output logic                                                 vga_de,
    output logic [COLOR_W-1:0]                                   vga_r,
    output logic [COLOR_W-1:0]                                   vga_g,
    output logic [COLOR_W-1:0]                                   vga_b,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]         pix_x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]         pix_y,
    output logic                                                 frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int B_W     = $clog2(BAR_W + 1);

    localparam logic [X_W-1:0] H_LAST  = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT_X = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_BEG  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END  = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST  = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT_Y = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_BEG  = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END  = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [B_W-1:0] BAR_LAST = B_W'(BAR_W - 1);

    logic [X_W-1:0]     h_q, h_d;
    logic [Y_W-1:0]     v_q, v_d;
    logic [B_W-1:0]     bar_cnt_q, bar_cnt_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [1:0]         mode_q, mode_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [X_W-1:0]     px_q;
    logic [Y_W-1:0]     py_q;
    logic               grid_on;
    logic [COLOR_W-1:0] grad_r, grad_g;

    // Counters, plus a bar sub-counter that tracks h_q so the bar index needs no divider.
    always_comb begin
        h_d       = h_q + 1'b1;
        v_d       = v_q;
        bar_cnt_d = bar_cnt_q + 1'b1;
        bar_idx_d = bar_idx_q;
        if (h_q == H_LAST) begin
            h_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
            v_d       = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 1'b1;
        end
    end

    always_comb begin
        fs_d    = (h_q == '0) && (v_q == '0);
        mode_d  = fs_d ? mode : mode_q;
        de_d    = (h_q < H_ACT_X) && (v_q < V_ACT_Y);
        hs_d    = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
        vs_d    = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
        grid_on = (h_q[GRID_LOG2-1:0] == '0) || (v_q[GRID_LOG2-1:0] == '0);
        grad_r  = COLOR_W'(h_q);
        grad_g  = COLOR_W'(v_q);
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        if (de_d) begin
            case (mode_d)
                2'd0: {r_d, g_d, b_d} = solid_rgb;
                2'd1: begin
                    // Bar order W,Y,C,G,M,R,B,K maps each channel to one inverted index bit.
                    r_d = {COLOR_W{~bar_idx_q[1]}};
                    g_d = {COLOR_W{~bar_idx_q[2]}};
                    b_d = {COLOR_W{~bar_idx_q[0]}};
                end
                2'd2: begin
                    r_d = {COLOR_W{grid_on}};
                    g_d = {COLOR_W{grid_on}};
                    b_d = {COLOR_W{grid_on}};
                end
                default: begin
                    r_d = grad_r;
                    g_d = grad_g;
                    b_d = grad_r + grad_g;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            h_q       <= '0;
            v_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= 2'd0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            px_q      <= '0;
            py_q      <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            px_q      <= h_q;
            py_q      <= v_q;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign pix_x       = px_q;
    assign pix_y       = py_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a wide-line instance with a short frame and a tiny active-high-sync instance,
// both checked every cycle against a pixel model, plus table vectors and multi-cycle sequences.
module tb_vga_timing_gen;
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [15:0] x;
        logic [15:0] y;
        logic        fs;
    } obs_t;

    typedef struct {
        int          d;
        int          x;
        int          y;
        logic [1:0]  md;
        logic [23:0] solid;
        logic [23:0] exp_rgb;
    } vec_t;

    localparam int HT_A = 800, VT_A = 24, FRAME_A = HT_A * VT_A;
    localparam int HT_B = 14,  VT_B = 7,  FRAME_B = HT_B * VT_B;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [1:0]  mode_a = 2'd0, mode_b = 2'd0;
    logic [23:0] solid_a = 24'h0, solid_b = 24'h0;

    logic       hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic [9:0] x_a;
    logic [4:0] y_a;
    logic [3:0] x_b;
    logic [2:0] y_b;
    obs_t       oa, ob;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .GRID_LOG2(5)
    ) dut_a (
        .vga_clk(clk), .rst(rst_a), .mode(mode_a), .solid_rgb(solid_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .GRID_LOG2(1)
    ) dut_b (
        .vga_clk(clk), .rst(rst_b), .mode(mode_b), .solid_rgb(solid_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b)
    );

    assign oa = {hs_a, vs_a, de_a, r_a, g_a, b_a, 16'(x_a), 16'(y_a), fs_a};
    assign ob = {hs_b, vs_b, de_b, r_b, g_b, b_b, 16'(x_b), 16'(y_b), fs_b};

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic obs_t model(input int d, input int h, input int v,
                                   input logic [1:0] md, input logic [23:0] solid);
        obs_t o;
        int ha, hfp, hsw, va, vfp, vsw, gp, bar;
        logic pol;
        if (d == 0) begin
            ha = 640; hfp = 16; hsw = 96; va = 16; vfp = 2; vsw = 2; pol = 1'b0; gp = 32;
        end else begin
            ha = 8; hfp = 2; hsw = 2; va = 4; vfp = 1; vsw = 1; pol = 1'b1; gp = 2;
        end
        o    = '0;
        o.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
        o.vs = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
        o.de = (h < ha) && (v < va);
        o.x  = 16'(h);
        o.y  = 16'(v);
        o.fs = (h == 0) && (v == 0);
        if (o.de) begin
            case (md)
                2'd0: {o.r, o.g, o.b} = solid;
                2'd1: begin
                    bar = h / (ha / 8);
                    case (bar)
                        0:       {o.r, o.g, o.b} = 24'hFFFFFF;
                        1:       {o.r, o.g, o.b} = 24'hFFFF00;
                        2:       {o.r, o.g, o.b} = 24'h00FFFF;
                        3:       {o.r, o.g, o.b} = 24'h00FF00;
                        4:       {o.r, o.g, o.b} = 24'hFF00FF;
                        5:       {o.r, o.g, o.b} = 24'hFF0000;
                        6:       {o.r, o.g, o.b} = 24'h0000FF;
                        default: {o.r, o.g, o.b} = 24'h000000;
                    endcase
                end
                2'd2: if (h % gp == 0 || v % gp == 0) {o.r, o.g, o.b} = 24'hFFFFFF;
                default: begin
                    o.r = 8'(h % 256);
                    o.g = 8'(v % 256);
                    o.b = 8'((h + v) % 256);
                end
            endcase
        end
        return o;
    endfunction

    function automatic obs_t reset_obs(input int d);
        obs_t o;
        o    = '0;
        o.hs = (d == 0);
        o.vs = (d == 0);
        return o;
    endfunction

    // Scoreboard: expected pixel pushed at each clock edge, popped at the following falling edge.
    int         mh [2];
    int         mv [2];
    logic [1:0] mlat [2];
    obs_t       q_a [$];
    obs_t       q_b [$];

    task automatic step(input int d, input logic r, input logic [1:0] md, input logic [23:0] solid);
        obs_t e;
        int   ht, vtot;
        ht   = (d == 0) ? HT_A : HT_B;
        vtot = (d == 0) ? VT_A : VT_B;
        if (r) begin
            mh[d] = 0; mv[d] = 0; mlat[d] = 2'd0;
            if (d == 0) q_a.delete(); else q_b.delete();
        end else begin
            if (mh[d] == 0 && mv[d] == 0) mlat[d] = md;
            e = model(d, mh[d], mv[d], mlat[d], solid);
            if (d == 0) q_a.push_back(e); else q_b.push_back(e);
            if (mh[d] == ht - 1) begin
                mh[d] = 0;
                mv[d] = (mv[d] == vtot - 1) ? 0 : mv[d] + 1;
            end else begin
                mh[d] = mh[d] + 1;
            end
        end
    endtask

    task automatic check_dut(input int d, input logic r, input obs_t act);
        obs_t e;
        if (r) begin
            if (d == 0) q_a.delete(); else q_b.delete();
            cmp($sformatf("reset_state dut%0d", d), 64'(act), 64'(reset_obs(d)));
        end else if (d == 0 && q_a.size() > 0) begin
            e = q_a.pop_front();
            cmp($sformatf("stream dut0 (%0d,%0d)", e.x, e.y), 64'(act), 64'(e));
        end else if (d == 1 && q_b.size() > 0) begin
            e = q_b.pop_front();
            cmp($sformatf("stream dut1 (%0d,%0d)", e.x, e.y), 64'(act), 64'(e));
        end
    endtask

    always @(posedge clk) begin
        step(0, rst_a, mode_a, solid_a);
        step(1, rst_b, mode_b, solid_b);
    end

    always @(negedge clk) begin
        check_dut(0, rst_a, oa);
        check_dut(1, rst_b, ob);
    end

    task automatic restart(input int d, input logic [1:0] md, input logic [23:0] solid);
        @(negedge clk);
        #2;
        if (d == 0) begin rst_a = 1'b1; mode_a = md; solid_a = solid; end
        else        begin rst_b = 1'b1; mode_b = md; solid_b = solid; end
        repeat (2) @(negedge clk);
        if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [23:0] rgb;
        logic [15:0] px, py;
        restart(v.d, v.md, v.solid);
        repeat (v.y * ((v.d == 0) ? HT_A : HT_B) + v.x + 1) @(posedge clk);
        #1;
        rgb = (v.d == 0) ? {r_a, g_a, b_a} : {r_b, g_b, b_b};
        px  = (v.d == 0) ? 16'(x_a) : 16'(x_b);
        py  = (v.d == 0) ? 16'(y_a) : 16'(y_b);
        cmp($sformatf("vec dut%0d mode%0d (%0d,%0d)", v.d, v.md, v.x, v.y),
            64'({px, py, rgb}), 64'({16'(v.x), 16'(v.y), v.exp_rgb}));
    endtask

    task automatic seq_timing_a();
        int   t_de = -1, hs_f1 = -1, hs_f2 = -1, hs_r = -1, vs_f = -1, vs_r = -1;
        int   fs1 = -1, fs2 = -1, fs_n = 0;
        logic pde = 1'b0, phs = 1'b1, pvs = 1'b1;
        restart(0, 2'd0, 24'h0);
        for (int c = 1; c <= 2 * FRAME_A; c++) begin
            @(posedge clk);
            #1;
            if (de_a && !pde && t_de < 0) t_de = c;
            if (!hs_a && phs) begin
                if (hs_f1 < 0) hs_f1 = c;
                else if (hs_f2 < 0) hs_f2 = c;
            end
            if (hs_a && !phs && hs_f1 >= 0 && hs_r < 0) hs_r = c;
            if (!vs_a && pvs && vs_f < 0) vs_f = c;
            if (vs_a && !pvs && vs_f >= 0 && vs_r < 0) vs_r = c;
            if (fs_a) begin
                fs_n++;
                if (fs1 < 0) fs1 = c;
                else if (fs2 < 0) fs2 = c;
            end
            pde = de_a; phs = hs_a; pvs = vs_a;
        end
        cmp("de_first_cycle", 64'(t_de), 64'd1);
        cmp("hs_period", 64'(hs_f2 - hs_f1), 64'd800);
        cmp("hs_offset_from_de", 64'(hs_f1 - t_de), 64'd656);
        cmp("hs_width", 64'(hs_r - hs_f1), 64'd96);
        cmp("vs_width", 64'(vs_r - vs_f), 64'd1600);
        cmp("fs_period", 64'(fs2 - fs1), 64'(FRAME_A));
        cmp("fs_count", 64'(fs_n), 64'd2);
    endtask

    task automatic seq_mode_switch();
        restart(0, 2'd0, 24'h123456);
        repeat (5 * HT_A + 100 + 1) @(posedge clk);
        #1 mode_a = 2'd1;
        repeat (100) @(posedge clk);
        #1 cmp("switch_hold (200,5)", 64'({r_a, g_a, b_a}), 64'h123456);
        repeat (FRAME_A - (5 * HT_A + 200)) @(posedge clk);
        #1 cmp("switch_next_frame (0,0)", 64'({fs_a, r_a, g_a, b_a}), 64'h1FFFFFF);
    endtask

    task automatic seq_small_b();
        int hs_first = -1, hs_n = 0, fs1 = -1, fs2 = -1, fs_n = 0;
        restart(1, 2'd3, 24'h0);
        for (int c = 1; c <= 3 * FRAME_B; c++) begin
            @(posedge clk);
            #1;
            if (c <= HT_B && hs_b) begin
                hs_n++;
                if (hs_first < 0) hs_first = c;
            end
            if (fs_b) begin
                fs_n++;
                if (fs1 < 0) fs1 = c;
                else if (fs2 < 0) fs2 = c;
            end
        end
        cmp("small_hs_first", 64'(hs_first), 64'd11);
        cmp("small_hs_len", 64'(hs_n), 64'd2);
        cmp("small_fs_period", 64'(fs2 - fs1), 64'd98);
        cmp("small_fs_count", 64'(fs_n), 64'd3);
        repeat (34) @(posedge clk);
        #1 cmp("small_pre_reset (5,2)", 64'({de_b, r_b, g_b}), 64'({1'b1, 8'd5, 8'd2}));
        #1 rst_b = 1'b1;
        #1 cmp("small_async_reset", 64'(ob), 64'(reset_obs(1)));
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1 cmp("small_restart_origin", 64'({fs_b, de_b, x_b, y_b}), 64'({1'b1, 1'b1, 4'd0, 3'd0}));
    endtask

    vec_t vt [19];

    initial begin
        vt[0]  = '{0, 0,   0, 2'd1, 24'h0, 24'hFFFFFF};
        vt[1]  = '{0, 79,  0, 2'd1, 24'h0, 24'hFFFFFF};
        vt[2]  = '{0, 80,  0, 2'd1, 24'h0, 24'hFFFF00};
        vt[3]  = '{0, 160, 0, 2'd1, 24'h0, 24'h00FFFF};
        vt[4]  = '{0, 400, 0, 2'd1, 24'h0, 24'hFF0000};
        vt[5]  = '{0, 560, 0, 2'd1, 24'h0, 24'h000000};
        vt[6]  = '{0, 640, 0, 2'd1, 24'h0, 24'h000000};
        vt[7]  = '{0, 799, 0, 2'd1, 24'h0, 24'h000000};
        vt[8]  = '{0, 32,  1, 2'd2, 24'h0, 24'hFFFFFF};
        vt[9]  = '{0, 33,  1, 2'd2, 24'h0, 24'h000000};
        vt[10] = '{0, 5,   0, 2'd2, 24'h0, 24'hFFFFFF};
        vt[11] = '{0, 300, 5, 2'd3, 24'h0, 24'h2C0531};
        vt[12] = '{0, 10,  3, 2'd0, 24'hABCDEF, 24'hABCDEF};
        vt[13] = '{1, 7,   3, 2'd3, 24'h0, 24'h07030A};
        vt[14] = '{1, 3,   0, 2'd1, 24'h0, 24'h00FF00};
        vt[15] = '{1, 1,   1, 2'd2, 24'h0, 24'h000000};
        vt[16] = '{1, 2,   1, 2'd2, 24'h0, 24'hFFFFFF};
        vt[17] = '{1, 9,   0, 2'd0, 24'hABCDEF, 24'h000000};
        vt[18] = '{1, 4,   5, 2'd0, 24'hABCDEF, 24'h000000};

        #100;
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (50) @(negedge clk);

        foreach (vt[i]) run_vec(vt[i]);
        seq_timing_a();
        seq_mode_switch();
        seq_small_b();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
